// File: rtl/booth_mul_sequencer.sv
`default_nettype none
//============================================================================
// Module      : booth_mul_sequencer
// Description : Streams operand pairs through a FIFO into a start/done Booth
//               multiplier and returns products on a valid/ready stream.
//               Optional macro BOOTH_SEQ_TIMEOUT_EN adds a sticky err_timeout.
// Revision    : 1.0 - initial release
//============================================================================
module booth_mul_sequencer #(
  parameter int N       = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_p,
  output logic         mul_start,
  output logic [N-1:0] mul_multiplicand,
  output logic [N-1:0] mul_multiplier,
  input  logic [N-1:0] mul_product,
  input  logic         mul_done,
  output logic         busy
`ifdef BOOTH_SEQ_TIMEOUT_EN
  ,
  output logic         err_timeout
`endif
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int              c_TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_TW-1:0] c_WAIT_LAST = c_TW'(TIMEOUT - 1);
`else
  localparam int              c_unused_timeout = TIMEOUT;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [N-1:0]      r_mem_a [DEPTH];
  logic [N-1:0]      r_mem_b [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              r_wait_first;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_release;

`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic [c_TW-1:0]   r_wait_cnt;
  logic              w_timeout;
`endif

  assign w_full   = (r_count == c_FULL);
  assign w_empty  = (r_count == '0);
  assign in_ready = !rst && !w_full;
  assign w_push   = in_valid && in_ready;
  assign busy     = !w_empty || (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !out_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done level still high from the previous product is not trusted
        // in the first WAIT cycle.
        if (!r_wait_first && mul_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
`ifdef BOOTH_SEQ_TIMEOUT_EN
        else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_wait_first     <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      out_valid        <= 1'b0;
      out_p            <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      mul_start <= w_pop;
      // Operands are only reloaded on a pop, so they hold through WAIT.
      if (w_pop) begin
        mul_multiplicand <= r_mem_a[r_rd_ptr];
        mul_multiplier   <= r_mem_b[r_rd_ptr];
      end
      r_wait_first <= (r_state == ST_ISSUE);
      if (w_capture) begin
        out_p     <= mul_product;
        out_valid <= 1'b1;
      end else if (w_release) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
